// File: rtl/cordic_iter_ctrl.sv
// Iterative 8-bit CORDIC rotation-mode sequencer: one micro-rotation per clock,
// direction from the sign of the residual angle, registered results with a done pulse.
module cordic_iter_ctrl #(
  parameter int ITERATIONS = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic signed [7:0] x_in,
  input  logic signed [7:0] y_in,
  input  logic signed [7:0] z_in,
  output logic              busy,
  output logic              done,
  output logic signed [7:0] x_out,
  output logic signed [7:0] y_out,
  output logic signed [7:0] z_out,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] LAST_ITER = 3'(ITERATIONS - 1);

  state_t            state, state_nxt;
  logic [2:0]        iter;
  logic signed [7:0] xw, yw, zw;
  logic signed [7:0] x_nxt, y_nxt, z_nxt;
  logic signed [7:0] x_sh, y_sh, atan_val;
  logic              d_neg;

  // round(atan(2^-i) * 64), angle scale 1 rad = 64 LSB
  always_comb begin
    atan_val = 8'sd0;
    case (iter)
      3'd0:    atan_val = 8'sd50;
      3'd1:    atan_val = 8'sd30;
      3'd2:    atan_val = 8'sd16;
      3'd3:    atan_val = 8'sd8;
      3'd4:    atan_val = 8'sd4;
      3'd5:    atan_val = 8'sd2;
      3'd6:    atan_val = 8'sd1;
      default: atan_val = 8'sd0;
    endcase
  end

  // One micro-rotation from pre-edge values; all sums wrap at 8 bits.
  always_comb begin
    d_neg = zw[7];
    x_sh  = xw >>> iter;
    y_sh  = yw >>> iter;
    if (d_neg) begin
      x_nxt = xw + y_sh;
      y_nxt = yw - x_sh;
      z_nxt = zw + atan_val;
    end else begin
      x_nxt = xw - y_sh;
      y_nxt = yw + x_sh;
      z_nxt = zw - atan_val;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (iter == LAST_ITER) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter  <= 3'd0;
      xw    <= 8'sd0;
      yw    <= 8'sd0;
      zw    <= 8'sd0;
      x_out <= 8'sd0;
      y_out <= 8'sd0;
      z_out <= 8'sd0;
    end else begin
      if (state == IDLE && start) begin
        xw   <= x_in;
        yw   <= y_in;
        zw   <= z_in;
        iter <= 3'd0;
      end else if (state == RUN) begin
        xw   <= x_nxt;
        yw   <= y_nxt;
        zw   <= z_nxt;
        iter <= iter + 3'd1;
        // Results only move on the final iteration; they hold across later runs.
        if (iter == LAST_ITER) begin
          x_out <= x_nxt;
          y_out <= y_nxt;
          z_out <= z_nxt;
        end
      end
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Directed bench for cordic_iter_ctrl: a 7-iteration and a 1-iteration instance
// checked against hand-computed CORDIC results and cycle timing.
module tb_cordic_iter_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start7, start1;
  logic [7:0] x_in, y_in, z_in;
  logic       busy7, done7, busy1, done1;
  logic [7:0] x_out7, y_out7, z_out7, x_out1, y_out1, z_out1;
  logic [1:0] state7, state1;

  int checks = 0;
  int errors = 0;

  cordic_iter_ctrl #(.ITERATIONS(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .start(start7),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .busy(busy7), .done(done7),
    .x_out(x_out7), .y_out(y_out7), .z_out(z_out7),
    .state_dbg(state7)
  );

  cordic_iter_ctrl #(.ITERATIONS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .busy(busy1), .done(done1),
    .x_out(x_out1), .y_out(y_out1), .z_out(z_out1),
    .state_dbg(state1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: present operands and a one-cycle start; returns just after edge E0
  task automatic start_op(input bit sel1, input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] z);
    @(negedge clk);
    x_in = x; y_in = y; z_in = z;
    if (sel1) start1 = 1'b1; else start7 = 1'b1;
    @(posedge clk);
    #1;
    start7 = 1'b0;
    start1 = 1'b0;
  endtask

  // monitor: samples n_edges cycles at negedge; k indexes edges after the call
  task automatic observe(input bit sel1, input int n_edges, input int inject_k,
                         output int first_done, output int second_done,
                         output int busy_cyc, output int done_cyc, output int overlap);
    logic b, d;
    first_done = -1; second_done = -1; busy_cyc = 0; done_cyc = 0; overlap = 0;
    for (int k = 0; k < n_edges; k++) begin
      @(negedge clk);
      b = sel1 ? busy1 : busy7;
      d = sel1 ? done1 : done7;
      if (b) busy_cyc++;
      if (d) begin
        done_cyc++;
        if (first_done < 0) first_done = k;
        else if (second_done < 0) second_done = k;
      end
      if (b && d) overlap++;
      if (k == inject_k) begin
        x_in = 8'd1; y_in = 8'd2; z_in = 8'd3;
        start7 = 1'b1;
      end
      if (inject_k >= 0 && k == inject_k + 1) start7 = 1'b0;
      @(posedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy7 !== 1'b0 || done7 !== 1'b0) begin
      errors++; $display("FAIL reset_low_flags busy=%b done=%b exp 0 0", busy7, done7);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (busy7 !== 1'b0 || done7 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
      errors++; $display("FAIL reset_flags busy7=%b done7=%b busy1=%b done1=%b exp 0", busy7, done7, busy1, done1);
    end
    checks++;
    if (x_out7 !== 8'h00 || y_out7 !== 8'h00 || z_out7 !== 8'h00) begin
      errors++; $display("FAIL reset_outputs got %h %h %h exp 00 00 00", x_out7, y_out7, z_out7);
    end
    checks++;
    if (state7 !== 2'd0 || state1 !== 2'd0) begin
      errors++; $display("FAIL reset_state got %0d %0d exp 0", state7, state1);
    end
  endtask

  task automatic test_default_run();
    int fd, sd, bc, dc, ov;
    start_op(1'b0, 8'd40, 8'd0, 8'd0);
    observe(1'b0, 16, -1, fd, sd, bc, dc, ov);
    checks++;
    if (fd !== 7) begin errors++; $display("FAIL default_latency got %0d exp 7", fd); end
    checks++;
    if (bc !== 7) begin errors++; $display("FAIL default_busy_cycles got %0d exp 7", bc); end
    checks++;
    if (dc !== 1 || ov !== 0) begin
      errors++; $display("FAIL default_done_pulse got %0d pulses %0d overlap exp 1 0", dc, ov);
    end
    checks++;
    if (x_out7 !== 8'd66 || y_out7 !== 8'd2 || z_out7 !== 8'hFF) begin
      errors++; $display("FAIL default_result got %h %h %h exp 42 02 ff", x_out7, y_out7, z_out7);
    end
  endtask

  // second vector (0,40,0) -> (-2,66,-1); previous result must hold during RUN
  task automatic test_vector2();
    int fd, sd, bc, dc, ov;
    start_op(1'b0, 8'd0, 8'd40, 8'd0);
    observe(1'b0, 3, -1, fd, sd, bc, dc, ov);
    #1;
    checks++;
    if (x_out7 !== 8'd66 || y_out7 !== 8'd2 || z_out7 !== 8'hFF) begin
      errors++; $display("FAIL result_hold got %h %h %h exp 42 02 ff", x_out7, y_out7, z_out7);
    end
    observe(1'b0, 12, -1, fd, sd, bc, dc, ov);
    checks++;
    if (fd !== 4 || dc !== 1) begin
      errors++; $display("FAIL vec2_done got edge %0d pulses %0d exp 4 1", fd, dc);
    end
    checks++;
    if (x_out7 !== 8'hFE || y_out7 !== 8'h42 || z_out7 !== 8'hFF) begin
      errors++; $display("FAIL vec2_result got %h %h %h exp fe 42 ff", x_out7, y_out7, z_out7);
    end
  endtask

  task automatic test_sign_boundary();
    int fd, sd, bc, dc, ov;
    start_op(1'b1, 8'd40, 8'd0, 8'h7F);
    observe(1'b1, 4, -1, fd, sd, bc, dc, ov);
    checks++;
    if (fd !== 1 || bc !== 1 || dc !== 1) begin
      errors++; $display("FAIL iter1_timing got done_edge %0d busy %0d pulses %0d exp 1 1 1", fd, bc, dc);
    end
    checks++;
    if (x_out1 !== 8'd40 || y_out1 !== 8'd40 || z_out1 !== 8'd77) begin
      errors++; $display("FAIL sign_7f got %0d %0d %0d exp 40 40 77", x_out1, y_out1, z_out1);
    end
    start_op(1'b1, 8'd40, 8'd0, 8'h80);
    observe(1'b1, 4, -1, fd, sd, bc, dc, ov);
    checks++;
    if (x_out1 !== 8'd40 || y_out1 !== 8'hD8 || z_out1 !== 8'hB2) begin
      errors++; $display("FAIL sign_80 got %h %h %h exp 28 d8 b2", x_out1, y_out1, z_out1);
    end
  endtask

  task automatic test_zero_angle();
    int fd, sd, bc, dc, ov;
    start_op(1'b1, 8'd40, 8'd0, 8'h00);
    observe(1'b1, 4, -1, fd, sd, bc, dc, ov);
    checks++;
    if (x_out1 !== 8'd40 || y_out1 !== 8'd40 || z_out1 !== 8'hCE) begin
      errors++; $display("FAIL zero_angle got %h %h %h exp 28 28 ce", x_out1, y_out1, z_out1);
    end
  endtask

  task automatic test_start_while_busy();
    int fd, sd, bc, dc, ov;
    start_op(1'b0, 8'd40, 8'd0, 8'd0);
    observe(1'b0, 16, 3, fd, sd, bc, dc, ov);
    checks++;
    if (dc !== 1 || fd !== 7) begin
      errors++; $display("FAIL busy_start_pulses got %0d at edge %0d exp 1 at 7", dc, fd);
    end
    checks++;
    if (x_out7 !== 8'd66 || y_out7 !== 8'd2 || z_out7 !== 8'hFF) begin
      errors++; $display("FAIL busy_start_result got %h %h %h exp 42 02 ff", x_out7, y_out7, z_out7);
    end
  endtask

  task automatic test_back_to_back();
    int fd, sd, bc, dc, ov;
    @(negedge clk);
    x_in = 8'd40; y_in = 8'd0; z_in = 8'd0;
    start7 = 1'b1;
    @(posedge clk);
    observe(1'b0, 20, -1, fd, sd, bc, dc, ov);
    checks++;
    if (fd !== 7 || sd !== 16) begin
      errors++; $display("FAIL b2b_period got done edges %0d %0d exp 7 16", fd, sd);
    end
    checks++;
    if (ov !== 0 || dc !== 2) begin
      errors++; $display("FAIL b2b_pulses got %0d overlap %0d exp 2 0", dc, ov);
    end
    start7 = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (state7 !== 2'd0 || x_out7 !== 8'd66) begin
      errors++; $display("FAIL b2b_drain got state %0d x %h exp 0 42", state7, x_out7);
    end
  endtask

  task automatic test_mid_reset();
    int fd, sd, bc, dc, ov;
    start_op(1'b0, 8'd0, 8'd40, 8'd0);
    observe(1'b0, 4, -1, fd, sd, bc, dc, ov);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy7 !== 1'b0 || done7 !== 1'b0 || state7 !== 2'd0) begin
      errors++; $display("FAIL midrst_flags got busy %b done %b state %0d exp 0 0 0", busy7, done7, state7);
    end
    checks++;
    if (x_out7 !== 8'h00 || y_out7 !== 8'h00 || z_out7 !== 8'h00) begin
      errors++; $display("FAIL midrst_outputs got %h %h %h exp 00 00 00", x_out7, y_out7, z_out7);
    end
    @(negedge clk);
    rst_n = 1'b1;
    observe(1'b0, 12, -1, fd, sd, bc, dc, ov);
    checks++;
    if (dc !== 0 || bc !== 0) begin
      errors++; $display("FAIL midrst_no_done got %0d pulses %0d busy exp 0 0", dc, bc);
    end
    start_op(1'b0, 8'd40, 8'd0, 8'd0);
    observe(1'b0, 12, -1, fd, sd, bc, dc, ov);
    checks++;
    if (fd !== 7 || x_out7 !== 8'd66 || y_out7 !== 8'd2 || z_out7 !== 8'hFF) begin
      errors++; $display("FAIL midrst_rerun got edge %0d %h %h %h exp 7 42 02 ff", fd, x_out7, y_out7, z_out7);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start7 = 1'b0;
    start1 = 1'b0;
    x_in   = 8'd0;
    y_in   = 8'd0;
    z_in   = 8'd0;
    test_reset();
    test_default_run();
    test_vector2();
    test_sign_boundary();
    test_zero_angle();
    test_start_while_busy();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
